audio_sample_sync: RTL and testbench

Sample-rate sequencer between the MCP3008 audio ADC interface and the IIR difference-equation filter/PWM DAC. Generates the fixed system sample strobe (fs) from CLOCK_50 and latches the newest ADC word. On each strobe it shifts the x[n]/x[n-1] history. After a settle window it commits the filter result as y[n-1] and as the DAC word. This gives the filter stable, single-clock-domain operands for a full sample period and tells it the true fs.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/fs_tick_gen.sv | 31 +++
 rtl/audio_sample_sync.sv | 155 +++++++++++++++
 tb/tb_audio_sample_sync.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample path: sample word type,
// sequencer states and the sample-rate divider calculation.
package audio_pkg;

    localparam int N_BITS = 10;
    localparam int CLK_HZ = 50_000_000;

    typedef logic [N_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        COMMIT
    } sync_state_t;

    // Integer clock divider for a requested rate; the remainder is dropped,
    // so the achieved rate is clk_hz / calc_div(...), slightly above fs_hz.
    function automatic int calc_div(input int clk_hz, input int fs_hz);
        return clk_hz / fs_hz;
    endfunction

endpackage

// File: rtl/fs_tick_gen.sv
// Free-running modulo-DIV counter producing a one-cycle strobe on its last count.
// Reused for both the audio sample rate and the pot ADC poll rate.
module fs_tick_gen #(
    parameter int DIV = 1041
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    output logic fs_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fs_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/audio_sample_sync.sv
// Sample-rate sequencer: holds the newest ADC word, shifts x[n]/x[n-1] on each
// fs tick, then commits the settled filter output as y[n-1] and the DAC word.
module audio_sample_sync
    import audio_pkg::*;
#(
    parameter int N          = N_BITS,
    parameter int CLK_HZ     = audio_pkg::CLK_HZ,
    parameter int FS_HZ      = 48000,
    parameter int SETTLE_CYC = 2
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic [N-1:0]  adc_data,
    input  logic          adc_valid,
    input  logic [N-1:0]  filt_data,
    output logic [N-1:0]  x_n,
    output logic [N-1:0]  x_n1,
    output logic [N-1:0]  y_n1,
    output logic [N-1:0]  dac_data,
    output logic          dac_valid,
    output logic          fs_tick,
    output logic [16:0]   fs_out,
    output logic          underrun,
    output logic [7:0]    drop_cnt
);

    localparam int DIV    = calc_div(CLK_HZ, FS_HZ);
    localparam int FS_ACT = CLK_HZ / DIV;
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYC - 1);

    logic tick;

    sync_state_t       state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [N-1:0]      hold_q, hold_d;
    logic              fresh_q, fresh_d;
    logic [N-1:0]      x_n_q, x_n_d;
    logic [N-1:0]      x_n1_q, x_n1_d;
    logic [N-1:0]      y_n1_q, y_n1_d;
    logic [N-1:0]      dac_q, dac_d;
    logic              dac_valid_q, dac_valid_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        drop_q, drop_d;

    fs_tick_gen #(
        .DIV (DIV)
    ) u_fs_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .fs_tick  (tick)
    );

    // Sample hold and history. A tick consumes the old hold before a
    // same-cycle adc_valid refills it, so that case never counts as a drop.
    always_comb begin
        // NOTE: every signal written here gets its hold value first so no latch is inferred.
        hold_d     = hold_q;
        fresh_d    = fresh_q;
        x_n_d      = x_n_q;
        x_n1_d     = x_n1_q;
        underrun_d = underrun_q;
        drop_d     = drop_q;

        if (tick) begin
            x_n1_d = x_n_q;
            if (fresh_q) begin
                x_n_d   = hold_q;
                fresh_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (adc_valid) begin
            hold_d  = adc_data;
            fresh_d = 1'b1;
            if (fresh_q && !tick && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Settle sequencer: waits SETTLE_CYC cycles after a tick for the
    // combinational filter to resolve, then commits its output once.
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        y_n1_d      = y_n1_q;
        dac_d       = dac_q;
        dac_valid_d = 1'b0;

        case (state_q)
            WAIT: begin
                if (tick) begin
                    state_d = SETTLE;
                    scnt_d  = '0;
                end
            end
            SETTLE: begin
                scnt_d = scnt_q + SCNT_W'(1);
                if (scnt_q == SCNT_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                y_n1_d      = filt_data;
                dac_d       = filt_data;
                dac_valid_d = 1'b1;
                state_d     = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT;
            scnt_q      <= '0;
            hold_q      <= '0;
            fresh_q     <= 1'b0;
            x_n_q       <= '0;
            x_n1_q      <= '0;
            y_n1_q      <= '0;
            dac_q       <= '0;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            hold_q      <= hold_d;
            fresh_q     <= fresh_d;
            x_n_q       <= x_n_d;
            x_n1_q      <= x_n1_d;
            y_n1_q      <= y_n1_d;
            dac_q       <= dac_d;
            dac_valid_q <= dac_valid_d;
            underrun_q  <= underrun_d;
            drop_q      <= drop_d;
        end
    end

    assign x_n       = x_n_q;
    assign x_n1      = x_n1_q;
    assign y_n1      = y_n1_q;
    assign dac_data  = dac_q;
    assign dac_valid = dac_valid_q;
    assign fs_tick   = tick;
    assign fs_out    = 17'(FS_ACT);
    assign underrun  = underrun_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_audio_sample_sync.sv
// Bench for audio_sample_sync: directed scenarios plus a cycle scoreboard
// driven by a queue-based model of the sample hold and commit schedule.
module tb_audio_sample_sync;

    localparam int N      = 10;
    localparam int DIV    = 1041;
    localparam int SETTLE = 2;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b1;
    logic [N-1:0]  adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [N-1:0]  filt_data = '0;
    logic [N-1:0]  x_n, x_n1, y_n1, dac_data;
    logic          dac_valid, fs_tick, underrun;
    logic [16:0]   fs_out;
    logic [7:0]    drop_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a pending-sample queue of depth at most one,
    // history values, and the cycle in which the next commit happens.
    logic [N-1:0] m_pend[$];
    logic [N-1:0] m_xn, m_xn1, m_y, m_dac;
    bit           m_dv, m_und;
    int           m_drop;
    int           m_commit_at;

    audio_sample_sync dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .filt_data (filt_data),
        .x_n       (x_n),
        .x_n1      (x_n1),
        .y_n1      (y_n1),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .fs_tick   (fs_tick),
        .fs_out    (fs_out),
        .underrun  (underrun),
        .drop_cnt  (drop_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic model_reset();
        m_pend.delete();
        m_xn = '0; m_xn1 = '0; m_y = '0; m_dac = '0;
        m_dv = 1'b0; m_und = 1'b0; m_drop = 0;
        m_commit_at = -1;
    endtask

    // Advance the model by one cycle with this cycle's inputs.
    task automatic model_cycle(input bit v, input logic [N-1:0] d);
        bit tick;
        tick = ((cyc % DIV) == DIV - 1);
        m_dv = (cyc == m_commit_at);
        if (m_dv) begin
            m_y   = filt_data;
            m_dac = filt_data;
        end
        if (tick) begin
            m_xn1 = m_xn;
            if (m_pend.size() > 0) m_xn = m_pend.pop_front();
            else                   m_und = 1'b1;
            m_commit_at = cyc + SETTLE + 1;
        end
        if (v) begin
            if (m_pend.size() > 0) begin
                m_pend[0] = d;
                if (m_drop < 255) m_drop++;
            end else begin
                m_pend.push_back(d);
            end
        end
    endtask

    // Compare all outputs against the model, then drive one cycle.
    task automatic step(input bit v, input logic [N-1:0] d);
        bit exp_tick;
        exp_tick = ((cyc % DIV) == DIV - 1);
        total++; if (fs_tick !== exp_tick) begin bad++; $display("FAIL sb_fs_tick cyc=%0d got=%b exp=%b", cyc, fs_tick, exp_tick); end
        total++; if (x_n !== m_xn) begin bad++; $display("FAIL sb_x_n cyc=%0d got=%h exp=%h", cyc, x_n, m_xn); end
        total++; if (x_n1 !== m_xn1) begin bad++; $display("FAIL sb_x_n1 cyc=%0d got=%h exp=%h", cyc, x_n1, m_xn1); end
        total++; if (y_n1 !== m_y) begin bad++; $display("FAIL sb_y_n1 cyc=%0d got=%h exp=%h", cyc, y_n1, m_y); end
        total++; if (dac_data !== m_dac) begin bad++; $display("FAIL sb_dac_data cyc=%0d got=%h exp=%h", cyc, dac_data, m_dac); end
        total++; if (dac_valid !== m_dv) begin bad++; $display("FAIL sb_dac_valid cyc=%0d got=%b exp=%b", cyc, dac_valid, m_dv); end
        total++; if (underrun !== m_und) begin bad++; $display("FAIL sb_underrun cyc=%0d got=%b exp=%b", cyc, underrun, m_und); end
        total++; if (drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL sb_drop_cnt cyc=%0d got=%0d exp=%0d", cyc, drop_cnt, m_drop); end
        adc_valid = v;
        adc_data  = d;
        model_cycle(v, d);
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1'b0, '0);
    endtask

    task automatic do_reset();
        adc_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        adc_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (x_n !== '0) begin bad++; $display("FAIL rst_x_n got=%h exp=0", x_n); end
        total++; if (x_n1 !== '0) begin bad++; $display("FAIL rst_x_n1 got=%h exp=0", x_n1); end
        total++; if (y_n1 !== '0) begin bad++; $display("FAIL rst_y_n1 got=%h exp=0", y_n1); end
        total++; if (dac_data !== '0) begin bad++; $display("FAIL rst_dac_data got=%h exp=0", dac_data); end
        total++; if (dac_valid !== 1'b0) begin bad++; $display("FAIL rst_dac_valid got=%b exp=0", dac_valid); end
        total++; if (fs_tick !== 1'b0) begin bad++; $display("FAIL rst_fs_tick got=%b exp=0", fs_tick); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
        total++; if (fs_out !== 17'd48030) begin bad++; $display("FAIL rst_fs_out got=%0d exp=48030", fs_out); end
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_no_input();
        int ticks[$];
        int exp_t[3] = '{1040, 2081, 3122};
        do_reset();
        while (cyc < 3125) begin
            if (fs_tick === 1'b1) ticks.push_back(cyc);
            step(1'b0, '0);
        end
        total++; if (ticks.size() != 3) begin bad++; $display("FAIL idle_tick_count got=%0d exp=3", ticks.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ticks.size() <= i || ticks[i] != exp_t[i]) begin
                bad++;
                $display("FAIL idle_tick_cycle idx=%0d got=%0d exp=%0d", i, (ticks.size() > i) ? ticks[i] : -1, exp_t[i]);
            end
        end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL idle_underrun got=%b exp=1", underrun); end
        total++; if (x_n !== '0) begin bad++; $display("FAIL idle_x_n got=%h exp=0", x_n); end
        total++; if (fs_out !== 17'd48030) begin bad++; $display("FAIL idle_fs_out got=%0d exp=48030", fs_out); end
    endtask

    task automatic test_samples();
        do_reset();
        run_to(100);
        step(1'b1, 10'h155);
        run_to(1041);
        total++; if (x_n !== 10'h155) begin bad++; $display("FAIL smp_x_n_1 got=%h exp=155", x_n); end
        total++; if (x_n1 !== 10'h000) begin bad++; $display("FAIL smp_x_n1_1 got=%h exp=000", x_n1); end
        run_to(1200);
        step(1'b1, 10'h2AA);
        run_to(2082);
        total++; if (x_n !== 10'h2AA) begin bad++; $display("FAIL smp_x_n_2 got=%h exp=2aa", x_n); end
        total++; if (x_n1 !== 10'h155) begin bad++; $display("FAIL smp_x_n1_2 got=%h exp=155", x_n1); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL smp_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_dac();
        int dv[$];
        do_reset();
        filt_data = 10'h3FF;
        while (cyc < 1060) begin
            if (dac_valid === 1'b1) dv.push_back(cyc);
            if (cyc == 1043) begin
                total++; if (y_n1 !== '0) begin bad++; $display("FAIL dac_early_y_n1 got=%h exp=000", y_n1); end
            end
            if (cyc == 1044) begin
                total++; if (dac_data !== 10'h3FF) begin bad++; $display("FAIL dac_data got=%h exp=3ff", dac_data); end
                total++; if (y_n1 !== 10'h3FF) begin bad++; $display("FAIL dac_y_n1 got=%h exp=3ff", y_n1); end
            end
            step(1'b0, '0);
        end
        total++; if (dv.size() != 1) begin bad++; $display("FAIL dac_valid_count got=%0d exp=1", dv.size()); end
        total++;
        if (dv.size() < 1 || dv[0] != 1044) begin
            bad++;
            $display("FAIL dac_valid_cycle got=%0d exp=1044", (dv.size() > 0) ? dv[0] : -1);
        end
    endtask

    task automatic test_drops();
        do_reset();
        run_to(10);  step(1'b1, 10'h001);
        run_to(20);  step(1'b1, 10'h002);
        run_to(30);  step(1'b1, 10'h003);
        run_to(40);
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL drop_three got=%0d exp=2", drop_cnt); end
        run_to(1041);
        total++; if (x_n !== 10'h003) begin bad++; $display("FAIL drop_newest got=%h exp=003", x_n); end
        run_to(1100);
        repeat (300) step(1'b1, N'($urandom));
        step(1'b0, '0);
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_saturate got=%0d exp=255", drop_cnt); end
    endtask

    task automatic test_coincident();
        do_reset();
        run_to(500);
        step(1'b1, 10'h055);
        run_to(1040);
        step(1'b1, 10'h0AA);
        total++; if (x_n !== 10'h055) begin bad++; $display("FAIL coin_x_n_1 got=%h exp=055", x_n); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL coin_drop_1 got=%0d exp=0", drop_cnt); end
        run_to(2082);
        total++; if (x_n !== 10'h0AA) begin bad++; $display("FAIL coin_x_n_2 got=%h exp=0aa", x_n); end
        total++; if (x_n1 !== 10'h055) begin bad++; $display("FAIL coin_x_n1_2 got=%h exp=055", x_n1); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL coin_drop_2 got=%0d exp=0", drop_cnt); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL coin_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_mid_reset();
        int dv_cnt = 0;
        do_reset();
        filt_data = 10'h123;
        run_to(50);
        step(1'b1, 10'h1C3);
        run_to(1042);
        total++; if (x_n !== 10'h1C3) begin bad++; $display("FAIL mrst_pre_x_n got=%h exp=1c3", x_n); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (x_n !== '0) begin bad++; $display("FAIL mrst_x_n got=%h exp=0", x_n); end
        total++; if (x_n1 !== '0) begin bad++; $display("FAIL mrst_x_n1 got=%h exp=0", x_n1); end
        total++; if (y_n1 !== '0) begin bad++; $display("FAIL mrst_y_n1 got=%h exp=0", y_n1); end
        total++; if (dac_data !== '0) begin bad++; $display("FAIL mrst_dac_data got=%h exp=0", dac_data); end
        total++; if (dac_valid !== 1'b0) begin bad++; $display("FAIL mrst_dac_valid got=%b exp=0", dac_valid); end
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        while (cyc < 1041) begin
            if (dac_valid === 1'b1) dv_cnt++;
            if (cyc == 1039) begin
                total++; if (fs_tick !== 1'b0) begin bad++; $display("FAIL mrst_early_tick got=%b exp=0", fs_tick); end
            end
            if (cyc == 1040) begin
                total++; if (fs_tick !== 1'b1) begin bad++; $display("FAIL mrst_first_tick got=%b exp=1", fs_tick); end
            end
            step(1'b0, '0);
        end
        total++; if (dv_cnt != 0) begin bad++; $display("FAIL mrst_dac_valid_count got=%0d exp=0", dv_cnt); end
    endtask

    task automatic test_random();
        bit v;
        do_reset();
        repeat (4200) begin
            // Every third sample period is silent so underrun gets exercised.
            if (((cyc / DIV) % 3) == 2) v = 1'b0;
            else                        v = ($urandom_range(0, 999) < 3);
            filt_data = N'($urandom);
            step(v, N'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_no_input();
        test_samples();
        test_dac();
        test_drops();
        test_coincident();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
